// File: rtl/mmio_req_ctrl.sv
// rtl/mmio_req_ctrl.sv - single-outstanding MMIO request sequencer with range/alignment checks
module mmio_req_ctrl #(
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_a000_0000,
    parameter logic [63:0] MMIO_SIZE = 64'h0000_0000_0100_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_flush,
    input  logic        req_is_store,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mmio_read_en,
    output logic        mmio_write_en,
    output logic [63:0] mmio_addr,
    output logic [3:0]  mmio_len,
    output logic [63:0] mmio_wdata,
    input  logic [63:0] mmio_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        is_store;
    logic        is_signed;
    logic        accept;
    logic        req_err;
    logic        len_ok;
    logic        misaligned;
    logic        below_base;
    logic        past_end;
    logic [63:0] len_mask;
    logic [64:0] end_addr;
    logic [64:0] limit;

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] len,
                                           input logic sgn);
        logic [63:0] r;
        case (len)
            4'd1:    r = sgn ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
            4'd2:    r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
            4'd4:    r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Window end compared at 65 bits so an address near 2^64 cannot wrap into range.
    always_comb begin
        len_ok     = (req_len == 4'd1) || (req_len == 4'd2) || (req_len == 4'd4) || (req_len == 4'd8);
        len_mask   = {60'd0, req_len} - 64'd1;
        misaligned = (req_addr & len_mask) != 64'd0;
        below_base = req_addr < MMIO_BASE;
        end_addr   = {1'b0, req_addr} + {61'd0, req_len};
        limit      = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};
        past_end   = end_addr > limit;
        req_err    = !len_ok || misaligned || below_base || past_end;
    end

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready && !req_flush;
    assign resp_valid    = (state == RESP);
    assign mmio_read_en  = (state == ISSUE) && !is_store;
    assign mmio_write_en = (state == ISSUE) && is_store;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_err ? RESP : ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            is_signed  <= 1'b0;
            mmio_addr  <= 64'd0;
            mmio_len   <= 4'd0;
            mmio_wdata <= 64'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                is_store   <= req_is_store;
                is_signed  <= req_signed;
                mmio_addr  <= req_addr;
                mmio_len   <= req_len;
                mmio_wdata <= req_wdata;
                resp_rdata <= 64'd0;
                resp_err   <= req_err;
            end
            if (state == ISSUE) begin
                resp_rdata <= is_store ? 64'd0 : extend(mmio_rdata, mmio_len, is_signed);
            end
        end
    end

endmodule

// File: tb/tb_mmio_req_ctrl.sv
// tb/tb_mmio_req_ctrl.sv - directed vector bench for mmio_req_ctrl
module tb_mmio_req_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_flush = 1'b0;
    logic        req_is_store = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [3:0]  req_len = 4'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mmio_read_en;
    logic        mmio_write_en;
    logic [63:0] mmio_addr;
    logic [3:0]  mmio_len;
    logic [63:0] mmio_wdata;
    logic [63:0] mmio_rdata = 64'd0;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;

    mmio_req_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_flush(req_flush),
        .req_is_store(req_is_store), .req_addr(req_addr), .req_len(req_len),
        .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mmio_read_en(mmio_read_en), .mmio_write_en(mmio_write_en),
        .mmio_addr(mmio_addr), .mmio_len(mmio_len), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mmio_read_en) rd_cnt <= rd_cnt + 1;
        if (mmio_write_en) wr_cnt <= wr_cnt + 1;
        if (mmio_read_en && mmio_write_en) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [63:0] addr, input logic [3:0] len,
                         input logic sgn, input logic [63:0] wdata);
        req_is_store = st;
        req_addr     = addr;
        req_len      = len;
        req_signed   = sgn;
        req_wdata    = wdata;
        req_valid    = 1'b1;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
    endtask

    typedef struct {
        logic        st;
        logic [63:0] addr;
        logic [3:0]  len;
        logic        sgn;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int r0, w0;
        vecs[0]  = '{1'b0, 64'ha000_0003, 4'd1, 1'b1, 64'd0, 64'h1111_2222_3333_0080, 1'b0, 64'hffff_ffff_ffff_ff80};
        vecs[1]  = '{1'b1, 64'ha000_0100, 4'd4, 1'b0, 64'h1234_5678, 64'hffff_ffff_ffff_ffff, 1'b0, 64'd0};
        vecs[2]  = '{1'b0, 64'ha000_0010, 4'd2, 1'b0, 64'd0, 64'h1234_8765, 1'b0, 64'h8765};
        vecs[3]  = '{1'b0, 64'ha000_0020, 4'd4, 1'b1, 64'd0, 64'hdead_beef_8000_0001, 1'b0, 64'hffff_ffff_8000_0001};
        vecs[4]  = '{1'b0, 64'ha0ff_fff8, 4'd8, 1'b1, 64'd0, 64'h0123_4567_89ab_cdef, 1'b0, 64'h0123_4567_89ab_cdef};
        vecs[5]  = '{1'b0, 64'ha000_0002, 4'd4, 1'b0, 64'd0, 64'h55, 1'b1, 64'd0};
        vecs[6]  = '{1'b0, 64'h8000_0000, 4'd4, 1'b0, 64'd0, 64'h55, 1'b1, 64'd0};
        vecs[7]  = '{1'b0, 64'ha000_0000, 4'd3, 1'b0, 64'd0, 64'h55, 1'b1, 64'd0};
        vecs[8]  = '{1'b1, 64'ha0ff_fffc, 4'd8, 1'b0, 64'h99, 64'h55, 1'b1, 64'd0};
        vecs[9]  = '{1'b1, 64'hffff_ffff_ffff_fff8, 4'd8, 1'b0, 64'h99, 64'h55, 1'b1, 64'd0};
        vecs[10] = '{1'b0, 64'ha000_0005, 4'd1, 1'b1, 64'd0, 64'hff7f, 1'b0, 64'h7f};

        #3;
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_resp_err", {63'd0, resp_err}, 64'd0);
        chk("reset_resp_rdata", resp_rdata, 64'd0);
        chk("reset_strobes", {62'd0, mmio_read_en, mmio_write_en}, 64'd0);
        chk("reset_mmio_addr", mmio_addr, 64'd0);
        chk("reset_mmio_len", {60'd0, mmio_len}, 64'd0);
        chk("reset_mmio_wdata", mmio_wdata, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("v%0d_ready_before", i), {63'd0, req_ready}, 64'd1);
            r0 = rd_cnt;
            w0 = wr_cnt;
            drive(vecs[i].st, vecs[i].addr, vecs[i].len, vecs[i].sgn, vecs[i].wdata);
            mmio_rdata = vecs[i].rdata;
            @(posedge clock);
            #1 req_valid = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_ready_busy", i), {63'd0, req_ready}, 64'd0);
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_read_en", i), {63'd0, mmio_read_en}, {63'd0, !vecs[i].st});
                chk($sformatf("v%0d_write_en", i), {63'd0, mmio_write_en}, {63'd0, vecs[i].st});
                chk($sformatf("v%0d_mmio_addr", i), mmio_addr, vecs[i].addr);
                chk($sformatf("v%0d_mmio_len", i), {60'd0, mmio_len}, {60'd0, vecs[i].len});
                chk($sformatf("v%0d_mmio_wdata", i), mmio_wdata, vecs[i].wdata);
                chk($sformatf("v%0d_early_resp", i), {63'd0, resp_valid}, 64'd0);
                @(negedge clock);
            end
            chk($sformatf("v%0d_resp_valid", i), {63'd0, resp_valid}, 64'd1);
            chk($sformatf("v%0d_resp_err", i), {63'd0, resp_err}, {63'd0, vecs[i].err});
            chk($sformatf("v%0d_resp_rdata", i), resp_rdata, vecs[i].exp);
            chk($sformatf("v%0d_strobe_in_resp", i), {62'd0, mmio_read_en, mmio_write_en}, 64'd0);
            handshake();
            chk($sformatf("v%0d_rd_count", i), 64'(rd_cnt - r0), {63'd0, !vecs[i].err && !vecs[i].st});
            chk($sformatf("v%0d_wr_count", i), 64'(wr_cnt - w0), {63'd0, !vecs[i].err && vecs[i].st});
            chk($sformatf("v%0d_ready_after", i), {63'd0, req_ready}, 64'd1);
            chk($sformatf("v%0d_resp_done", i), {63'd0, resp_valid}, 64'd0);
        end

        // Flushed store held for three cycles must not be written.
        r0 = rd_cnt;
        w0 = wr_cnt;
        req_flush = 1'b1;
        drive(1'b1, 64'ha000_0200, 4'd8, 1'b0, 64'hcafe_f00d_0000_0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("flush%0d_ready", k), {63'd0, req_ready}, 64'd1);
            chk($sformatf("flush%0d_strobes", k), {62'd0, mmio_read_en, mmio_write_en}, 64'd0);
            chk($sformatf("flush%0d_resp", k), {63'd0, resp_valid}, 64'd0);
        end
        chk("flush_no_write", 64'(wr_cnt - w0), 64'd0);
        req_flush = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("flush_then_write", {63'd0, mmio_write_en}, 64'd1);
        chk("flush_then_wdata", mmio_wdata, 64'hcafe_f00d_0000_0001);
        @(negedge clock);
        chk("flush_resp_valid", {63'd0, resp_valid}, 64'd1);
        handshake();
        chk("flush_write_total", 64'(wr_cnt - w0), 64'd1);

        // Back-pressure: response and data held while the consumer stalls.
        r0 = rd_cnt;
        drive(1'b0, 64'ha000_0030, 4'd2, 1'b1, 64'd0);
        mmio_rdata = 64'h7777_8001;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        mmio_rdata = 64'h0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), {63'd0, resp_valid}, 64'd1);
            chk($sformatf("bp%0d_rdata", k), resp_rdata, 64'hffff_ffff_ffff_8001);
            chk($sformatf("bp%0d_ready", k), {63'd0, req_ready}, 64'd0);
            @(negedge clock);
        end
        handshake();
        chk("bp_single_strobe", 64'(rd_cnt - r0), 64'd1);

        // Reset during ISSUE drops the strobe at once and no response follows.
        drive(1'b0, 64'ha000_0040, 4'd8, 1'b0, 64'd0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        chk("rst_issue_strobe_on", {63'd0, mmio_read_en}, 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_issue_strobe_off", {63'd0, mmio_read_en}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_release_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_release_resp", {63'd0, resp_valid}, 64'd0);
        @(negedge clock);
        chk("rst_no_late_resp", {63'd0, resp_valid}, 64'd0);
        chk("rst_no_late_strobe", {62'd0, mmio_read_en, mmio_write_en}, 64'd0);
        chk("never_both_strobes", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
